// File: rtl/seven_segments_to_bcd_if.sv
// Segment bus between a display source and the segment-to-BCD decoder.
interface seven_segments_to_bcd_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       Seg;
  logic [3:0]       Digit;
  logic             Valid;
  logic             Dash;
  logic             Error;
  logic [ERR_W-1:0] ErrCount;

  modport master (
    output Seg,
    input  Digit, Valid, Dash, Error, ErrCount
  );

  modport slave (
    input  Seg,
    output Digit, Valid, Dash, Error, ErrCount
  );
endinterface

// File: rtl/seven_segments_to_bcd.sv
// Seven-segment pattern to BCD decoder with a stability filter, dash/blank
// handling and a saturating illegal-pattern counter.
module seven_segments_to_bcd #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  seven_segments_to_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    CLS_DIGIT   = 2'd0,
    CLS_DASH    = 2'd1,
    CLS_BLANK   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } seg_class_e;

  typedef struct packed {
    seg_class_e cls;
    logic [3:0] digit;
  } seg_decode_t;

  // Bit order is g,f,e,d,c,b,a from MSB to LSB.
  function automatic seg_decode_t decode_seg(input logic [6:0] pat);
    seg_decode_t r;
    r.cls   = CLS_DIGIT;
    r.digit = 4'hF;
    case (pat)
      7'b0111111: r.digit = 4'd0;
      7'b0000110: r.digit = 4'd1;
      7'b1011011: r.digit = 4'd2;
      7'b1001111: r.digit = 4'd3;
      7'b1100110: r.digit = 4'd4;
      7'b1101101: r.digit = 4'd5;
      7'b1111101: r.digit = 4'd6;
      7'b0000111: r.digit = 4'd7;
      7'b1111111: r.digit = 4'd8;
      7'b1100111: r.digit = 4'd9;
      7'b1000000: r.cls   = CLS_DASH;
      7'b0000000: r.cls   = CLS_BLANK;
      default:    r.cls   = CLS_ILLEGAL;
    endcase
    return r;
  endfunction

  logic [6:0]       seg_q,     seg_d;
  logic [6:0]       cand_q,    cand_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [6:0]       acc_q,     acc_d;
  logic             acc_vld_q, acc_vld_d;
  logic [3:0]       digit_q,   digit_d;
  logic             valid_q,   valid_d;
  logic             dash_q,    dash_d;
  logic             error_q,   error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic        accept_s;
  seg_decode_t dec_s;

  assign dec_s = decode_seg(cand_q);

  // Accept fires on the edge where a held candidate completes its count.
  assign accept_s = (seg_q == cand_q)
                 && (cnt_q == CNT_W'(STABLE_CYCLES - 1))
                 && ((cand_q != acc_q) || !acc_vld_q);

  // Next-state: input sampling, stability filter and accept-time output update.
  always_comb begin
    seg_d     = bus.Seg;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    digit_d   = digit_q;
    valid_d   = 1'b0;
    dash_d    = dash_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;

    if (seg_q != cand_q) begin
      cand_d = seg_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      acc_d = cand_q;
      case (dec_s.cls)
        CLS_DIGIT: begin
          acc_vld_d = 1'b1;
          valid_d   = 1'b1;
          digit_d   = dec_s.digit;
          dash_d    = 1'b0;
          error_d   = 1'b0;
        end
        CLS_DASH: begin
          acc_vld_d = 1'b1;
          valid_d   = 1'b1;
          digit_d   = 4'hF;
          dash_d    = 1'b1;
          error_d   = 1'b0;
        end
        // Display off: forget the accepted value so a repeat re-strobes.
        CLS_BLANK: begin
          acc_vld_d = 1'b0;
        end
        CLS_ILLEGAL: begin
          acc_vld_d = 1'b1;
          valid_d   = 1'b1;
          digit_d   = 4'hF;
          dash_d    = 1'b0;
          error_d   = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end
        default: begin
          acc_vld_d = acc_vld_q;
        end
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seg_q     <= 7'd0;
      cand_q    <= 7'd0;
      cnt_q     <= '0;
      acc_q     <= 7'd0;
      acc_vld_q <= 1'b0;
      digit_q   <= 4'h0;
      valid_q   <= 1'b0;
      dash_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seg_q     <= seg_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      dash_q    <= dash_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.Digit    = digit_q;
  assign bus.Valid    = valid_q;
  assign bus.Dash     = dash_q;
  assign bus.Error    = error_q;
  assign bus.ErrCount = err_cnt_q;

endmodule

// File: tb/tb_seven_segments_to_bcd.sv
// Randomised and directed bench for seven_segments_to_bcd against a run-length
// behavioural model of the acceptance rules.
module tb_seven_segments_to_bcd;
  localparam int S     = 4;
  localparam int ERR_W = 8;

  logic clock;
  logic reset_n;
  int   vectors;
  int   errors;

  seven_segments_to_bcd_if #(.ERR_W(ERR_W)) bus ();

  seven_segments_to_bcd #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [6:0] digit_pat [10];
  logic [6:0] m_last, m_acc;
  int         m_run;
  logic       m_acc_vld;
  logic       exp_valid, exp_dash, exp_err;
  logic [3:0] exp_digit;
  logic [ERR_W-1:0] exp_cnt;

  // One clock: drive inputs, advance the model on the edge, settle past it.
  task automatic tick(input logic [6:0] seg, input logic rst_n_v);
    int d;
    bus.Seg = seg;
    reset_n = rst_n_v;
    @(posedge clock);
    if (!rst_n_v) begin
      m_last = 7'd0; m_run = 2; m_acc = 7'd0; m_acc_vld = 1'b0;
      exp_valid = 1'b0; exp_digit = 4'h0; exp_dash = 1'b0; exp_err = 1'b0;
      exp_cnt = '0;
    end else begin
      exp_valid = 1'b0;
      if (m_run == S + 1 && (m_last != m_acc || !m_acc_vld)) begin
        m_acc = m_last;
        if (m_last == 7'd0) begin
          m_acc_vld = 1'b0;
        end else begin
          m_acc_vld = 1'b1;
          exp_valid = 1'b1;
          d = -1;
          for (int k = 0; k < 10; k++) if (digit_pat[k] == m_last) d = k;
          if (d >= 0) begin
            exp_digit = 4'(d); exp_dash = 1'b0; exp_err = 1'b0;
          end else if (m_last == 7'b1000000) begin
            exp_digit = 4'hF; exp_dash = 1'b1; exp_err = 1'b0;
          end else begin
            exp_digit = 4'hF; exp_dash = 1'b0; exp_err = 1'b1;
            if (exp_cnt != {ERR_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
          end
        end
      end
      if (seg == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = seg;
        m_run  = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(7'd0, 1'b0);
    vectors++;
    if ({bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount} !== {1'b0, 4'h0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: got V%b D%h Da%b E%b C%0d, want all zero", bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount);
    end
    tick(7'd0, 1'b1);
  endtask

  task automatic test_first_accept();
    int nv = 0;
    int at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(7'b0111111, 1'b1);
      if (bus.Valid === 1'b1) begin nv++; at = i; end
      vectors++;
      if ({bus.Valid, bus.Digit, bus.Dash, bus.Error} !== {exp_valid, exp_digit, exp_dash, exp_err}) begin
        errors++;
        $display("FAIL first_accept cyc %0d: got V%b D%h Da%b E%b want V%b D%h Da%b E%b", i, bus.Valid, bus.Digit, bus.Dash, bus.Error, exp_valid, exp_digit, exp_dash, exp_err);
      end
    end
    vectors++;
    if (nv !== 1 || at !== S + 1 || bus.Digit !== 4'h0) begin
      errors++;
      $display("FAIL first_latency: got %0d pulses at edge %0d digit %h, want 1 at edge %0d digit 0", nv, at, bus.Digit, S + 1);
    end
  endtask

  task automatic test_sweep();
    int nv = 0;
    int ok = 1;
    for (int i = 0; i < 6; i++) tick(7'd0, 1'b1);
    for (int d = 0; d < 10; d++) begin
      for (int i = 0; i < 8; i++) begin
        tick(digit_pat[d], 1'b1);
        if (bus.Valid === 1'b1) begin
          nv++;
          if (bus.Digit !== 4'(d)) ok = 0;
        end
        vectors++;
        if ({bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount} !== {exp_valid, exp_digit, exp_dash, exp_err, exp_cnt}) begin
          errors++;
          $display("FAIL sweep digit %0d cyc %0d: got V%b D%h want V%b D%h", d, i, bus.Valid, bus.Digit, exp_valid, exp_digit);
        end
      end
    end
    vectors++;
    if (nv !== 10 || ok !== 1 || bus.ErrCount !== 8'd0) begin
      errors++;
      $display("FAIL sweep_summary: got %0d pulses in_order=%0d errcnt=%0d, want 10 1 0", nv, ok, bus.ErrCount);
    end
  endtask

  task automatic test_glitch();
    int nv = 0;
    for (int i = 0; i < 10; i++) tick(7'b1100110, 1'b1);
    for (int i = 0; i < 14; i++) begin
      tick((i < 2) ? 7'b1111111 : 7'b1100110, 1'b1);
      if (bus.Valid === 1'b1) nv++;
      vectors++;
      if ({bus.Valid, bus.Digit} !== {exp_valid, exp_digit}) begin
        errors++;
        $display("FAIL glitch cyc %0d: got V%b D%h want V%b D%h", i, bus.Valid, bus.Digit, exp_valid, exp_digit);
      end
    end
    vectors++;
    if (nv !== 0 || bus.Digit !== 4'd4) begin
      errors++;
      $display("FAIL glitch_summary: got %0d pulses digit %h, want 0 pulses digit 4", nv, bus.Digit);
    end
  endtask

  task automatic test_dash_error();
    logic [6:0] pats [2];
    pats[0] = 7'b1000000;
    pats[1] = 7'b0101010;
    for (int p = 0; p < 2; p++) begin
      int nv = 0;
      for (int i = 0; i < 8; i++) begin
        tick(pats[p], 1'b1);
        if (bus.Valid === 1'b1) nv++;
      end
      vectors++;
      if (p == 0 && {nv[3:0], bus.Digit, bus.Dash, bus.Error} !== {4'd1, 4'hF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL dash: got pulses %0d D%h Da%b E%b, want 1 F 1 0", nv, bus.Digit, bus.Dash, bus.Error);
      end
      if (p == 1 && {nv[3:0], bus.Digit, bus.Dash, bus.Error, bus.ErrCount} !== {4'd1, 4'hF, 1'b0, 1'b1, 8'd1}) begin
        errors++;
        $display("FAIL error: got pulses %0d D%h Da%b E%b C%0d, want 1 F 0 1 1", nv, bus.Digit, bus.Dash, bus.Error, bus.ErrCount);
      end
    end
  endtask

  task automatic test_blank();
    int nv [3];
    int len [3];
    logic [6:0] pats [3];
    pats[0] = 7'b0000110; pats[1] = 7'd0; pats[2] = 7'b0000110;
    len[0] = 8; len[1] = 10; len[2] = 8;
    for (int p = 0; p < 3; p++) begin
      nv[p] = 0;
      for (int i = 0; i < len[p]; i++) begin
        tick(pats[p], 1'b1);
        if (bus.Valid === 1'b1) nv[p]++;
        vectors++;
        if ({bus.Valid, bus.Digit, bus.Dash, bus.Error} !== {exp_valid, exp_digit, exp_dash, exp_err}) begin
          errors++;
          $display("FAIL blank phase %0d cyc %0d: got V%b D%h want V%b D%h", p, i, bus.Valid, bus.Digit, exp_valid, exp_digit);
        end
      end
    end
    vectors++;
    if (nv[0] !== 1 || nv[1] !== 0 || nv[2] !== 1 || bus.Digit !== 4'd1) begin
      errors++;
      $display("FAIL blank_summary: got pulses %0d/%0d/%0d digit %h, want 1/0/1 digit 1", nv[0], nv[1], nv[2], bus.Digit);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    int at = -1;
    for (int i = 0; i < 4; i++) tick(7'b1101101, 1'b1);
    tick(7'b1101101, 1'b0);
    vectors++;
    if ({bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount} !== {1'b0, 4'h0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid: got V%b D%h Da%b E%b C%0d, want all zero", bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount);
    end
    for (int i = 0; i < 10; i++) begin
      tick(7'b1101101, 1'b1);
      if (bus.Valid === 1'b1) begin nv++; at = i; end
    end
    vectors++;
    if (nv !== 1 || at !== S + 1 || bus.Digit !== 4'd5) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d pulses at edge %0d digit %h, want 1 at %0d digit 5", nv, at, bus.Digit, S + 1);
    end
  endtask

  task automatic test_random();
    logic [6:0] pat;
    int hold;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    pat = digit_pat[$urandom_range(0, 9)];
        2:       pat = 7'b1000000;
        3:       pat = 7'd0;
        default: pat = 7'($urandom_range(0, 127));
      endcase
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        tick(pat, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
        vectors++;
        if ({bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount} !== {exp_valid, exp_digit, exp_dash, exp_err, exp_cnt}) begin
          errors++;
          $display("FAIL random seg %h: got V%b D%h Da%b E%b C%0d want V%b D%h Da%b E%b C%0d", pat, bus.Valid, bus.Digit, bus.Dash, bus.Error, bus.ErrCount, exp_valid, exp_digit, exp_dash, exp_err, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) tick(7'd0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < S + 2; i++) begin
        tick((n % 2 == 0) ? 7'b0101010 : 7'b1010101, 1'b1);
        vectors++;
        if ({bus.Valid, bus.Error, bus.ErrCount} !== {exp_valid, exp_err, exp_cnt}) begin
          errors++;
          $display("FAIL saturation n %0d: got V%b E%b C%0d want V%b E%b C%0d", n, bus.Valid, bus.Error, bus.ErrCount, exp_valid, exp_err, exp_cnt);
        end
      end
    end
    vectors++;
    if (bus.ErrCount !== 8'hFF) begin
      errors++;
      $display("FAIL saturation_final: got %0d want 255", bus.ErrCount);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    digit_pat[0] = 7'b0111111; digit_pat[1] = 7'b0000110;
    digit_pat[2] = 7'b1011011; digit_pat[3] = 7'b1001111;
    digit_pat[4] = 7'b1100110; digit_pat[5] = 7'b1101101;
    digit_pat[6] = 7'b1111101; digit_pat[7] = 7'b0000111;
    digit_pat[8] = 7'b1111111; digit_pat[9] = 7'b1100111;
    reset_n = 1'b0;
    bus.Seg = 7'd0;
    test_reset();
    test_first_accept();
    test_sweep();
    test_glitch();
    test_dash_error();
    test_blank();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seven_segments_to_bcd.md
Name: seven_segments_to_bcd

Overview:
Decodes a 7-bit seven-segment pattern back into a BCD digit. It is the receive side of the segment encoding used by the display path, and is used for loopback checking of display drivers and for reading segment buses from external boards. The raw pattern is registered and must hold stable for a programmable number of cycles before it is accepted. Each accepted change produces a one-cycle Valid strobe, and illegal patterns are flagged and counted.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical registered samples required before acceptance; legal range 1..255.
ERR_W, 8, width of the saturating error counter.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  synchronous, active-low reset.
Seg  input  7  segment pattern, bit6..bit0 = g,f,e,d,c,b,a; active-high.
Digit  output  4  decoded BCD value of the last accepted pattern; 4'hF for dash or error.
Valid  output  1  one-cycle strobe when a new pattern is accepted.
Dash  output  1  level; the last accepted pattern was the dash code.
Error  output  1  level; the last accepted pattern was illegal.
ErrCount  output  ERR_W  saturating count of accepted illegal patterns.

Behaviour:
- Reset is synchronous: reset_n=0 sampled on a clock edge clears every register.
  - Reset values: Digit=4'h0, Valid=0, Dash=0, Error=0, ErrCount=0.
  - Internal state after reset: seg_q=0, cand=0, cnt=0, acc=0, acc_vld=0.
  - A partial stability count is discarded when reset hits mid-operation.
- Input stage: seg_q <= Seg every cycle. This is the only sampling point.
- Stability filter, evaluated each edge:
  - If seg_q != cand: cand <= seg_q, cnt <= 0.
  - Otherwise, if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - cnt width is clog2(STABLE_CYCLES+1); cnt saturates at STABLE_CYCLES.
- Accept event: occurs on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, and either (cand != acc) or (acc_vld == 0).
  - On that edge: acc <= cand, acc_vld <= 1, and the outputs update.
  - Valid is high for exactly the following cycle.
- Latency: if Seg changes before edge 0 and then holds, Valid is high in the cycle after edge STABLE_CYCLES+1 (after edge 5 for the default of 4).
- Decode table (pattern -> Digit):
  - 0111111 -> 0
  - 0000110 -> 1
  - 1011011 -> 2
  - 1001111 -> 3
  - 1100110 -> 4
  - 1101101 -> 5
  - 1111101 -> 6
  - 0000111 -> 7
  - 1111111 -> 8
  - 1100111 -> 9
- Dash: 1000000 gives Digit=F, Dash=1, Error=0, Valid pulses.
- Blank: 0000000 means display off.
  - On acceptance: acc_vld <= 0, no Valid, and Digit/Dash/Error hold their previous values.
  - Consequence: the same digit shown again after a blank produces a fresh Valid.
- Any other pattern: Digit=F, Error=1, Dash=0, Valid pulses, ErrCount <= ErrCount+1.
  - ErrCount saturates at 2^ERR_W-1.
- Dash and Error are levels held until the next accept. At most one of them is high at a time.
- Re-stabilising on the same pattern as acc (e.g. after a glitch shorter than STABLE_CYCLES) produces no Valid and no ErrCount increment.
- Glitches shorter than STABLE_CYCLES samples never reach the outputs.
- STABLE_CYCLES=1: acceptance happens on the first edge after cand updates.

Test Plan:
- Reset, then hold Seg=0111111 -> Valid high in exactly one cycle, after edge 5; Digit=0, Dash=0, Error=0; no further Valid while the pattern holds.
- Sweep all ten digit codes, each held 8 cycles -> ten Valid pulses, Digit = 0..9 in order, ErrCount=0.
- Hold 1100110 (4), insert a 2-cycle glitch to 1111111, return to 1100110 -> no Valid; Digit stays 4.
- Apply 1000000, then 0101010 -> first Valid with Dash=1 and Digit=F; second Valid with Error=1, Dash=0, ErrCount=1.
- Show 0000110, then 0000000 for 10 cycles, then 0000110 again -> Valid for the first 1, none during blank, Valid again with Digit=1.
- Drive reset_n=0 for one edge at cnt=2, mid-acceptance -> all outputs at reset values; the subsequent hold needs a full STABLE_CYCLES+1 edges before Valid.
- Force 300 alternating illegal patterns, each stable -> ErrCount saturates at 255.
